// File: rtl/mines_pkg.sv
// Shared encodings for the grid cursor block.
//   dir_e   : step direction, value doubles as the index of the KEY bit
//             that requests it (0 right, 1 left, 2 up, 3 down).
//   state_e : move FSM states.
//   pick_dir: priority encoder right > left > up > down over a 4-bit
//             falling-edge vector.
package mines_pkg;

  typedef enum logic [1:0] {
    DIR_R = 2'd0,
    DIR_L = 2'd1,
    DIR_U = 2'd2,
    DIR_D = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_e;

  function automatic dir_e pick_dir(input logic [3:0] f);
    if (f[0]) return DIR_R;
    if (f[1]) return DIR_L;
    if (f[2]) return DIR_U;
    return DIR_D;
  endfunction

endpackage

// File: rtl/grid_cursor_key_edge.sv
// key_edge: two-flop synchroniser plus falling-edge detector for the
// active-low button vector.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset (all flops go to 1 = released)
//   key  - raw asynchronous active-low buttons
//   ks   - synchronised buttons
//   fall - one-cycle high when a synchronised bit goes 1 -> 0
module key_edge (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key,
  output logic [3:0] ks,
  output logic [3:0] fall
);

  logic [3:0] s1;
  logic [3:0] ks_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= 4'hF;
      ks      <= 4'hF;
      ks_prev <= 4'hF;
    end else begin
      s1      <= key;
      ks      <= s1;
      ks_prev <= ks;
    end
  end

  // Resetting the history to 1 means a button still held when reset
  // releases reads as a fresh press; release it during reset to avoid that.
  assign fall = ks_prev & ~ks;

endmodule

// File: rtl/grid_cursor.sv
// grid_cursor: button-driven cursor on a GRID_W x GRID_H board with
// auto-repeat, action pulses and a cursor-highlight pixel colour.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   KEY[3:0]        - active-low buttons: 0 right, 1 left, 2 up, 3 down
//   switch          - 0 = move mode, 1 = action mode
//   xPixel, yPixel  - current scan position
//   active_pixels   - scan is inside the visible region
//   cursor_x/y      - cursor cell
//   place_flag      - pulse on right-button press in action mode
//   sel_sqr/start   - pulse together on left-button press in action mode
//   moved           - pulse whenever the cursor cell changes
//   vga_color       - {R,G,B} for the current scan pixel (combinational)
module grid_cursor
  import mines_pkg::*;
#(
  parameter int          GRID_W     = 16,
  parameter int          GRID_H     = 16,
  parameter int          CELL_W     = 40,
  parameter int          CELL_H     = 30,
  parameter logic [23:0] HOLD_TICKS = 24'd25_000_000,
  parameter logic [23:0] RPT_TICKS  = 24'd10_000_000,
  parameter bit          WRAP_EN    = 1'b0,
  parameter logic [23:0] CUR_COLOR  = 24'hF54927
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [3:0]                  KEY,
  input  logic                        switch,
  input  logic [9:0]                  xPixel,
  input  logic [9:0]                  yPixel,
  input  logic                        active_pixels,
  output logic [$clog2(GRID_W)-1:0]   cursor_x,
  output logic [$clog2(GRID_H)-1:0]   cursor_y,
  output logic                        place_flag,
  output logic                        sel_sqr,
  output logic                        sel_start,
  output logic                        moved,
  output logic [23:0]                 vga_color
);

  localparam int          CX_W    = $clog2(GRID_W);
  localparam int          CY_W    = $clog2(GRID_H);
  localparam logic [7:0]  MAX_X   = 8'(GRID_W - 1);
  localparam logic [7:0]  MAX_Y   = 8'(GRID_H - 1);
  localparam logic [31:0] BOARD_W = 32'(GRID_W * CELL_W);
  localparam logic [31:0] BOARD_H = 32'(GRID_H * CELL_H);

  // One step along an axis; coordinates are carried at 8 bits so the same
  // helper serves both axes for any grid up to 64 cells.
  function automatic logic [7:0] step_coord(input logic [7:0] cur,
                                            input logic       inc,
                                            input logic [7:0] max_v);
    if (inc) begin
      if (cur == max_v) return WRAP_EN ? 8'd0 : cur;
      return cur + 8'd1;
    end
    if (cur == 8'd0) return WRAP_EN ? max_v : cur;
    return cur - 8'd1;
  endfunction

  logic [3:0] ks;
  logic [3:0] fall;

  key_edge u_key_edge (
    .clk  (clk),
    .rst  (rst),
    .key  (KEY),
    .ks   (ks),
    .fall (fall)
  );

  state_e         state;
  dir_e           dir_q;
  logic [23:0]    tcnt;
  dir_e           dir_sel;
  logic [CX_W-1:0] step_x;
  logic [CY_W-1:0] step_y;
  logic           step_chg;

  // In IDLE the direction comes from the fresh edge; afterwards it is the
  // latched one so other buttons cannot redirect an active repeat.
  always_comb begin
    dir_sel = (state == IDLE) ? pick_dir(fall) : dir_q;
    step_x  = cursor_x;
    step_y  = cursor_y;
    case (dir_sel)
      DIR_R:   step_x = CX_W'(step_coord(8'(cursor_x), 1'b1, MAX_X));
      DIR_L:   step_x = CX_W'(step_coord(8'(cursor_x), 1'b0, MAX_X));
      DIR_U:   step_y = CY_W'(step_coord(8'(cursor_y), 1'b0, MAX_Y));
      default: step_y = CY_W'(step_coord(8'(cursor_y), 1'b1, MAX_Y));
    endcase
    step_chg = (step_x != cursor_x) || (step_y != cursor_y);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dir_q      <= DIR_R;
      tcnt       <= 24'd0;
      cursor_x   <= '0;
      cursor_y   <= '0;
      moved      <= 1'b0;
      place_flag <= 1'b0;
      sel_sqr    <= 1'b0;
      sel_start  <= 1'b0;
    end else begin
      moved      <= 1'b0;
      place_flag <= switch & fall[0];
      sel_sqr    <= switch & fall[1];
      sel_start  <= switch & fall[1];
      case (state)
        IDLE: begin
          if (!switch && (fall != 4'd0)) begin
            dir_q    <= dir_sel;
            cursor_x <= step_x;
            cursor_y <= step_y;
            moved    <= step_chg;
            tcnt     <= 24'd0;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (switch || ks[dir_q]) begin
            state <= IDLE;
          end else if (tcnt == HOLD_TICKS - 24'd1) begin
            cursor_x <= step_x;
            cursor_y <= step_y;
            moved    <= step_chg;
            tcnt     <= 24'd0;
            state    <= REPEAT;
          end else begin
            tcnt <= tcnt + 24'd1;
          end
        end
        REPEAT: begin
          if (switch || ks[dir_q]) begin
            state <= IDLE;
          end else if (tcnt == RPT_TICKS - 24'd1) begin
            cursor_x <= step_x;
            cursor_y <= step_y;
            moved    <= step_chg;
            tcnt     <= 24'd0;
          end else begin
            tcnt <= tcnt + 24'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [9:0] col_idx;
  logic [9:0] row_idx;
  logic [9:0] loc_x;
  logic [9:0] loc_y;
  logic       on_board;

  // Pixel indices stay at the full 10-bit scan width, so no cell index is
  // lost for any board that fits the scan range.
  always_comb begin
    col_idx   = xPixel / 10'(CELL_W);
    row_idx   = yPixel / 10'(CELL_H);
    loc_x     = xPixel % 10'(CELL_W);
    loc_y     = yPixel % 10'(CELL_H);
    on_board  = ({22'd0, xPixel} < BOARD_W) && ({22'd0, yPixel} < BOARD_H);
    vga_color = 24'h000000;
    if (active_pixels && on_board && (loc_x != 10'd0) && (loc_y != 10'd0) &&
        (col_idx == 10'(cursor_x)) && (row_idx == 10'(cursor_y)))
      vga_color = CUR_COLOR;
  end

endmodule

// File: tb/tb_grid_cursor.sv
module tb_grid_cursor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] KEY = 4'hF;
  logic       switch = 1'b0;
  logic [9:0] xPixel = 10'd0;
  logic [9:0] yPixel = 10'd0;
  logic       active_pixels = 1'b0;

  logic [3:0]  cx0, cy0, cx1, cy1;
  logic        pf0, ss0, st0, mv0;
  logic        pf1, ss1, st1, mv1;
  logic [23:0] col0, col1;

  int tests = 0;
  int fails = 0;
  int mcnt0 = 0, mcnt1 = 0, pcnt = 0, sqcnt = 0, stcnt = 0, bothcnt = 0;
  int b_m0, b_m1, b_p, b_sq, b_st, b_both;

  always #5 clk = ~clk;

  grid_cursor #(.HOLD_TICKS(24'd8), .RPT_TICKS(24'd4), .WRAP_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .KEY(KEY), .switch(switch), .xPixel(xPixel),
    .yPixel(yPixel), .active_pixels(active_pixels), .cursor_x(cx0),
    .cursor_y(cy0), .place_flag(pf0), .sel_sqr(ss0), .sel_start(st0),
    .moved(mv0), .vga_color(col0));

  grid_cursor #(.HOLD_TICKS(24'd8), .RPT_TICKS(24'd4), .WRAP_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .KEY(KEY), .switch(switch), .xPixel(xPixel),
    .yPixel(yPixel), .active_pixels(active_pixels), .cursor_x(cx1),
    .cursor_y(cy1), .place_flag(pf1), .sel_sqr(ss1), .sel_start(st1),
    .moved(mv1), .vga_color(col1));

  always @(posedge clk) begin
    if (mv0) mcnt0++;
    if (mv1) mcnt1++;
    if (pf0) pcnt++;
    if (ss0) sqcnt++;
    if (st0) stcnt++;
    if (pf0 && ss0 && st0) bothcnt++;
  end

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        act;
    logic [23:0] exp;
  } vvec_t;

  vvec_t vt[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] k);
    KEY = k;
    tick(1);
    KEY = 4'hF;
    tick(6);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    KEY = 4'hF;
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic snap();
    b_m0 = mcnt0; b_m1 = mcnt1; b_p = pcnt; b_sq = sqcnt; b_st = stcnt; b_both = bothcnt;
  endtask

  initial begin
    vt[0]  = '{10'd41,  10'd31,  1'b1, 24'hF54927};
    vt[1]  = '{10'd40,  10'd31,  1'b1, 24'h000000};
    vt[2]  = '{10'd41,  10'd30,  1'b1, 24'h000000};
    vt[3]  = '{10'd41,  10'd31,  1'b0, 24'h000000};
    vt[4]  = '{10'd79,  10'd59,  1'b1, 24'hF54927};
    vt[5]  = '{10'd50,  10'd45,  1'b1, 24'hF54927};
    vt[6]  = '{10'd80,  10'd31,  1'b1, 24'h000000};
    vt[7]  = '{10'd1,   10'd1,   1'b1, 24'h000000};
    vt[8]  = '{10'd41,  10'd61,  1'b1, 24'h000000};
    vt[9]  = '{10'd641, 10'd31,  1'b1, 24'h000000};
    vt[10] = '{10'd41,  10'd481, 1'b1, 24'h000000};

    // Reset state
    tick(3);
    chk("rst_x", 32'(cx0), 32'd0);
    chk("rst_y", 32'(cy0), 32'd0);
    chk("rst_pulses", {28'd0, pf0, ss0, st0, mv0}, 32'd0);
    rst = 1'b0;
    tick(2);

    // Single short press
    snap();
    press(4'b1110);
    tick(4);
    chk("single_x", 32'(cx0), 32'd1);
    chk("single_moved", 32'(mcnt0 - b_m0), 32'd1);
    chk("single_x_wrapdut", 32'(cx1), 32'd1);

    // Hold with auto-repeat
    do_reset();
    snap();
    KEY = 4'b1110;
    tick(30);
    KEY = 4'hF;
    tick(10);
    chk("hold_x", 32'(cx0), 32'd7);
    chk("hold_y", 32'(cy0), 32'd0);
    chk("hold_moved", 32'(mcnt0 - b_m0), 32'd7);
    tick(20);
    chk("hold_idle_x", 32'(cx0), 32'd7);

    // Pixel colour with cursor at (1,1)
    do_reset();
    press(4'b1110);
    press(4'b0111);
    chk("vga_cur_x", 32'(cx0), 32'd1);
    chk("vga_cur_y", 32'(cy0), 32'd1);
    for (int i = 0; i < 11; i++) begin
      xPixel = vt[i].x;
      yPixel = vt[i].y;
      active_pixels = vt[i].act;
      #1;
      chk($sformatf("vga%0d", i), 32'(col0), 32'(vt[i].exp));
      chk($sformatf("vga%0d_w", i), 32'(col1), 32'(vt[i].exp));
    end
    active_pixels = 1'b0;

    // Up and left back to origin
    press(4'b1011);
    press(4'b1101);
    chk("up_y", 32'(cy0), 32'd0);
    chk("left_x", 32'(cx0), 32'd0);

    // Simultaneous edges in move mode: right wins
    press(4'b0000);
    chk("prio_x", 32'(cx0), 32'd1);
    chk("prio_y", 32'(cy0), 32'd0);

    // Edge behaviour: clamp vs wrap
    do_reset();
    for (int i = 0; i < 15; i++) press(4'b1110);
    chk("edge_x0", 32'(cx0), 32'd15);
    chk("edge_x1", 32'(cx1), 32'd15);
    snap();
    press(4'b1110);
    chk("clamp_x", 32'(cx0), 32'd15);
    chk("clamp_moved", 32'(mcnt0 - b_m0), 32'd0);
    chk("wrap_x", 32'(cx1), 32'd0);
    chk("wrap_moved", 32'(mcnt1 - b_m1), 32'd1);
    press(4'b1101);
    chk("wrapl_x", 32'(cx1), 32'd15);
    chk("clampl_x", 32'(cx0), 32'd14);
    do_reset();
    press(4'b1011);
    chk("clamp_y0", 32'(cy0), 32'd0);
    chk("wrap_y0", 32'(cy1), 32'd15);

    // Action mode pulses
    do_reset();
    press(4'b1110);
    switch = 1'b1;
    tick(3);
    snap();
    press(4'b1100);
    tick(4);
    chk("act_place", 32'(pcnt - b_p), 32'd1);
    chk("act_sqr", 32'(sqcnt - b_sq), 32'd1);
    chk("act_start", 32'(stcnt - b_st), 32'd1);
    chk("act_together", 32'(bothcnt - b_both), 32'd1);
    chk("act_x", 32'(cx0), 32'd1);
    chk("act_moved", 32'(mcnt0 - b_m0), 32'd0);
    press(4'b1011);
    chk("act_up_y", 32'(cy0), 32'd0);

    // Move-mode edges give no action pulses
    switch = 1'b0;
    tick(3);
    snap();
    press(4'b1101);
    chk("move_nopulse", 32'(pcnt - b_p + sqcnt - b_sq), 32'd0);
    chk("move_left_x", 32'(cx0), 32'd0);

    // switch=1 during HOLD aborts, switch toggle makes no pulse
    do_reset();
    snap();
    KEY = 4'b1110;
    tick(5);
    switch = 1'b1;
    tick(20);
    KEY = 4'hF;
    tick(4);
    switch = 1'b0;
    tick(4);
    chk("sw_abort_x", 32'(cx0), 32'd1);
    chk("sw_nopulse", 32'(pcnt - b_p), 32'd0);

    // Reset during REPEAT
    do_reset();
    KEY = 4'b1110;
    tick(20);
    chk("rep_pre_x", 32'(cx0), 32'd4);
    rst = 1'b1;
    tick(2);
    chk("rep_rst_x", 32'(cx0), 32'd0);
    chk("rep_rst_y", 32'(cy0), 32'd0);
    chk("rep_rst_moved", 32'(mv0), 32'd0);
    KEY = 4'hF;
    tick(3);
    rst = 1'b0;
    tick(12);
    chk("rep_after_x", 32'(cx0), 32'd0);
    press(4'b1110);
    chk("rep_new_x", 32'(cx0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/grid_cursor.md
GRID_CURSOR -- requirements
Module: grid_cursor

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- GRID_W, 16, columns.
- GRID_H, 16, rows.
- CELL_W, 40, cell width in pixels.
- CELL_H, 30, cell height in pixels.
- HOLD_TICKS, 24'd25_000_000, first-repeat delay in clk cycles.
- RPT_TICKS, 24'd10_000_000, repeat period in clk cycles.
- WRAP_EN, 0, 1 = cursor wraps at edges, 0 = cursor clamps.
- CUR_COLOR, 24'hF54927, cursor fill colour.

REQ-002 SHALL have ports (name, direction, width, meaning). The design uses one clock; reset is synchronous and active-high.
- clk, in, 1, sole clock.
- rst, in, 1, synchronous reset, active-high.
- KEY, in, 4, active-low buttons: [0] right, [1] left, [2] up, [3] down.
- switch, in, 1, 0 = move mode, 1 = action mode.
- xPixel, in, 10, scan x.
- yPixel, in, 10, scan y.
- active_pixels, in, 1, visible region.
- cursor_x, out, $clog2(GRID_W), cursor column.
- cursor_y, out, $clog2(GRID_H), cursor row.
- place_flag, out, 1, one-cycle pulse.
- sel_sqr, out, 1, one-cycle pulse.
- sel_start, out, 1, one-cycle pulse.
- moved, out, 1, one-cycle pulse on every cursor change.
- vga_color, out, 24, packed {R,G,B}.

Function
REQ-003 SHALL pass each KEY bit through a 2-flop synchroniser (reset value 1); all logic below uses the synchronised bits (ks).

REQ-004 SHALL run a single move FSM with states IDLE, HOLD and REPEAT, and a 24-bit counter tcnt.

REQ-005 In IDLE with switch=0, a falling edge of any ks bit SHALL select the direction by priority right > left > up > down, step once, load tcnt=0 and go to HOLD.

REQ-006 HOLD SHALL step again and go to REPEAT when tcnt==HOLD_TICKS-1; REPEAT SHALL step each time tcnt==RPT_TICKS-1; tcnt SHALL clear on each step.

REQ-007 From HOLD or REPEAT, releasing the latched key, or switch=1, SHALL return the FSM to IDLE with no step; other keys are ignored until IDLE.

REQ-008 Step arithmetic:
- WRAP_EN=0: saturate at 0 and GRID_W-1 / GRID_H-1, with no moved pulse when saturated.
- WRAP_EN=1: GRID_W-1 right goes to 0, and 0 left goes to GRID_W-1; y behaves the same way.

REQ-009 moved SHALL be registered and asserted in the cycle after any cursor_x/cursor_y change.

REQ-010 With switch=1:
- A ks[0] falling edge SHALL produce place_flag=1 for exactly one cycle, registered (one cycle after the edge is detected).
- A ks[1] falling edge SHALL pulse sel_sqr and sel_start together in the same way.
- Simultaneous edges SHALL produce both pulses.

REQ-011 Edges that occur while switch=0 SHALL NOT produce action pulses; a switch change SHALL NOT itself generate pulses.

REQ-012 vga_color SHALL be combinational:
- 24'h000000 when !active_pixels, outside the GRID_W*CELL_W by GRID_H*CELL_H board, or on a grid line (local_x==0 or local_y==0).
- Otherwise CUR_COLOR when the pixel cell equals (cursor_x, cursor_y).
- Otherwise 24'h000000.

REQ-013 Cell index and local offset SHALL be computed by division and modulo by CELL_W/CELL_H at sufficient width, with no truncation for GRID up to 64.

Reset
REQ-014 With rst=1 at a clk edge:
- cursor_x=0, cursor_y=0.
- FSM=IDLE, tcnt=0.
- Synchroniser and edge registers = 1.
- place_flag, sel_sqr, sel_start and moved = 0.

REQ-015 Reset mid-HOLD or mid-REPEAT SHALL abort the repeat, and no step SHALL occur in the reset cycle.

Structure
REQ-016 Direction encoding (DIR_R, DIR_L, DIR_U, DIR_D) and the FSM state encoding SHALL live in shared package mines_pkg.

REQ-017 The synchroniser plus falling-edge detector SHALL be one sub-module, key_edge, instantiated once for the 4-bit vector.

REQ-018 The pixel-colour logic SHALL remain in grid_cursor.

Verification (benches override HOLD_TICKS=8, RPT_TICKS=4)
REQ-019 Reset then press KEY[0] for 1 cycle pulse -> cursor_x=1 and moved pulses once; no further steps.

REQ-020 Hold KEY[0] low for 30 cycles from x=0 -> steps at press, +8, then every 4 -> cursor_x=7; release -> IDLE.

REQ-021 WRAP_EN=0, cursor_x=15, press right -> stays 15 with no moved pulse; WRAP_EN=1 -> cursor_x=0 and moved pulses.

REQ-022 switch=1, KEY[0] and KEY[1] fall in the same cycle -> place_flag, sel_sqr and sel_start each high exactly one cycle; cursor unchanged.

REQ-023 Assert rst during REPEAT with key held -> cursor (0,0) and FSM IDLE; after release, the held key steps only on a new falling edge.

REQ-024 Scan pixel (41,31) with cursor (1,1) -> vga_color=F54927; pixel (40,31) -> 000000 (grid line); active_pixels=0 -> 000000.
